// File: rtl/game_ctrl.sv
// Guess-the-number round controller: arms the timer, judges guesses, ends rounds in WIN or LOSE.
// Optional build macro GAME_SCORE_EN adds the score register; without it score is tied to 0.
module game_ctrl #(
    parameter int LIMIT_D1  = 32,
    parameter int LIMIT_D2  = 64,
    parameter int LIMIT_D3  = 96,
    parameter int MAX_TRIES = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] Max_digit,
    input  logic [6:0] secret,
    input  logic [6:0] guess,
    input  logic       guess_valid,
    input  logic [6:0] counter,
    output logic       timer_restart,
    output logic       too_high,
    output logic       too_low,
    output logic       bad_guess,
    output logic       win,
    output logic       lose,
    output logic [3:0] attempts,
    output logic       busy,
    output logic [7:0] score
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_PLAY, S_JUDGE, S_WIN, S_LOSE
    } state_t;

    state_t     state, state_nxt;
    logic       arm_cnt;
    logic [6:0] limit_q, range_q, secret_q, guess_q;
    logic [6:0] limit_sel, range_sel;
    logic       start_ok, timeout, in_range, hit, last_try;

    always_comb begin
        limit_sel = 7'(LIMIT_D1);
        range_sel = 7'd9;
        case (Max_digit)
            2'd2: begin limit_sel = 7'(LIMIT_D2); range_sel = 7'd99;  end
            2'd3: begin limit_sel = 7'(LIMIT_D3); range_sel = 7'd127; end
            default: ;
        endcase
    end

    assign start_ok = start && (state == S_IDLE || state == S_WIN || state == S_LOSE);
    assign timeout  = counter >= limit_q;
    assign in_range = guess <= range_q;
    assign hit      = guess_q == secret_q;
    assign last_try = attempts == 4'(MAX_TRIES);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_WIN, S_LOSE: if (start) state_nxt = S_ARM;
            S_ARM:   if (arm_cnt) state_nxt = S_PLAY;
            S_PLAY: begin
                if (timeout)                      state_nxt = S_LOSE;
                else if (guess_valid && in_range) state_nxt = S_JUDGE;
            end
            S_JUDGE: begin
                if (hit)           state_nxt = S_WIN;
                else if (last_try) state_nxt = S_LOSE;
                else               state_nxt = S_PLAY;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The timer keeps running through the single JUDGE cycle.
    assign timer_restart = (state == S_PLAY) || (state == S_JUDGE);
    assign busy          = (state == S_ARM) || timer_restart;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arm_cnt   <= 1'b0;
            limit_q   <= '0;
            range_q   <= '0;
            secret_q  <= '0;
            guess_q   <= '0;
            too_high  <= 1'b0;
            too_low   <= 1'b0;
            bad_guess <= 1'b0;
            win       <= 1'b0;
            lose      <= 1'b0;
            attempts  <= '0;
        end else begin
            arm_cnt <= (state == S_ARM) && !arm_cnt;
            if (start_ok) begin
                limit_q   <= limit_sel;
                range_q   <= range_sel;
                secret_q  <= secret;
                too_high  <= 1'b0;
                too_low   <= 1'b0;
                bad_guess <= 1'b0;
                win       <= 1'b0;
                lose      <= 1'b0;
                attempts  <= '0;
            end else if (state == S_PLAY) begin
                if (timeout) begin
                    lose <= 1'b1;
                end else if (guess_valid) begin
                    if (in_range) begin
                        guess_q  <= guess;
                        attempts <= attempts + 4'd1;
                    end else begin
                        bad_guess <= 1'b1;
                        too_high  <= 1'b0;
                        too_low   <= 1'b0;
                    end
                end
            end else if (state == S_JUDGE) begin
                bad_guess <= 1'b0;
                too_high  <= guess_q > secret_q;
                too_low   <= guess_q < secret_q;
                if (hit)           win  <= 1'b1;
                else if (last_try) lose <= 1'b1;
            end
        end
    end

`ifdef GAME_SCORE_EN
    logic [6:0] time_left;
    logic [3:0] tries_left;
    logic [8:0] score_sum;

    // Time left is clamped at zero in case the timer has run past the limit during JUDGE.
    assign time_left  = timeout ? 7'd0 : limit_q - counter;
    assign tries_left = 4'(MAX_TRIES) - attempts;
    assign score_sum  = {2'b00, time_left} + {3'b000, tries_left, 2'b00};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            score <= '0;
        else if (start_ok)
            score <= '0;
        else if (state == S_JUDGE && hit)
            score <= score_sum[8] ? 8'hFF : score_sum[7:0];
    end
`else
    assign score = '0;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed vector table, corner sequences and random play
// compared against a round-level reference model.
module tb_game_ctrl;
    localparam int MAX_TRIES = 7;

    logic       clk = 1'b0;
    logic       reset, start, guess_valid;
    logic [1:0] Max_digit;
    logic [6:0] secret, guess, counter;
    logic       timer_restart, too_high, too_low, bad_guess, win, lose, busy;
    logic [3:0] attempts;
    logic [7:0] score;

    game_ctrl #(.MAX_TRIES(MAX_TRIES)) dut (
        .clk(clk), .reset(reset), .start(start), .Max_digit(Max_digit),
        .secret(secret), .guess(guess), .guess_valid(guess_valid), .counter(counter),
        .timer_restart(timer_restart), .too_high(too_high), .too_low(too_low),
        .bad_guess(bad_guess), .win(win), .lose(lose), .attempts(attempts),
        .busy(busy), .score(score)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a round is either running (arming or playing) or over.
    int m_active, m_arm_left, m_pend, m_pguess, m_secret, m_limit, m_range;
    int m_att, m_hi, m_lo, m_bad, m_win, m_lose, m_score;

    task automatic model_reset();
        m_active = 0; m_arm_left = 0; m_pend = 0; m_pguess = 0; m_secret = 0;
        m_limit = 0; m_range = 0; m_att = 0; m_hi = 0; m_lo = 0; m_bad = 0;
        m_win = 0; m_lose = 0; m_score = 0;
    endtask

    task automatic model_step();
        int left;
        if (m_active == 0) begin
            if (start) begin
                m_limit  = (Max_digit == 2) ? 64 : (Max_digit == 3) ? 96 : 32;
                m_range  = (Max_digit == 2) ? 99 : (Max_digit == 3) ? 127 : 9;
                m_secret = int'(secret);
                m_hi = 0; m_lo = 0; m_bad = 0; m_win = 0; m_lose = 0; m_att = 0; m_score = 0;
                m_active = 1; m_arm_left = 2; m_pend = 0;
            end
        end else if (m_arm_left > 0) begin
            m_arm_left--;
        end else if (m_pend) begin
            m_pend = 0;
            m_bad  = 0;
            m_hi   = (m_pguess > m_secret) ? 1 : 0;
            m_lo   = (m_pguess < m_secret) ? 1 : 0;
            if (m_pguess == m_secret) begin
                m_win = 1; m_active = 0;
                left = (int'(counter) >= m_limit) ? 0 : m_limit - int'(counter);
                m_score = left + 4 * (MAX_TRIES - m_att);
                if (m_score > 255) m_score = 255;
            end else if (m_att == MAX_TRIES) begin
                m_lose = 1; m_active = 0;
            end
        end else begin
            if (int'(counter) >= m_limit) begin
                m_lose = 1; m_active = 0;
            end else if (guess_valid) begin
                if (int'(guess) > m_range) begin
                    m_bad = 1; m_hi = 0; m_lo = 0;
                end else begin
                    m_pguess = int'(guess); m_att++; m_pend = 1;
                end
            end
        end
    endtask

    function automatic int m_restart();
        return (m_active != 0 && m_arm_left == 0) ? 1 : 0;
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".timer_restart"}, 32'(timer_restart), m_restart());
        chk({tag, ".busy"},      32'(busy),      m_active);
        chk({tag, ".too_high"},  32'(too_high),  m_hi);
        chk({tag, ".too_low"},   32'(too_low),   m_lo);
        chk({tag, ".bad_guess"}, 32'(bad_guess), m_bad);
        chk({tag, ".win"},       32'(win),       m_win);
        chk({tag, ".lose"},      32'(lose),      m_lose);
        chk({tag, ".attempts"},  32'(attempts),  m_att);
`ifdef GAME_SCORE_EN
        chk({tag, ".score"},     32'(score),     m_score);
`else
        chk({tag, ".score"},     32'(score),     0);
`endif
    endtask

    task automatic cyc(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_model(tag);
        start       = 1'b0;
        guess_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; guess_valid = 1'b0;
        Max_digit = '0; secret = '0; guess = '0; counter = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        reset = 1'b0;
    endtask

    task automatic begin_round(input logic [1:0] md, input logic [6:0] sec, input string tag);
        Max_digit = md; secret = sec; start = 1'b1;
        cyc(tag);
        cyc(tag);
        cyc(tag);
    endtask

    typedef struct {
        int st, md, sec, gv, g;
        int rs, bz, hi, lo, bd, wn, ls, at;
    } vec_t;

    vec_t tv[10];

    initial begin
        //         st md sec gv g   rs bz hi lo bd wn ls at
        tv[0] = '{1, 1, 5,  0, 0,  0, 1, 0, 0, 0, 0, 0, 0};
        tv[1] = '{0, 0, 0,  1, 5,  0, 1, 0, 0, 0, 0, 0, 0};
        tv[2] = '{0, 0, 0,  0, 0,  1, 1, 0, 0, 0, 0, 0, 0};
        tv[3] = '{0, 0, 0,  1, 8,  1, 1, 0, 0, 0, 0, 0, 1};
        tv[4] = '{1, 3, 3,  0, 0,  1, 1, 1, 0, 0, 0, 0, 1};
        tv[5] = '{0, 0, 0,  1, 3,  1, 1, 1, 0, 0, 0, 0, 2};
        tv[6] = '{0, 0, 0,  0, 0,  1, 1, 0, 1, 0, 0, 0, 2};
        tv[7] = '{0, 0, 0,  1, 5,  1, 1, 0, 1, 0, 0, 0, 3};
        tv[8] = '{0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 1, 0, 3};
        tv[9] = '{0, 0, 0,  1, 5,  0, 0, 0, 0, 0, 1, 0, 3};

        // Directed round: guesses 8, 3, 5 against secret 5.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            start       = 1'(tv[i].st);
            Max_digit   = 2'(tv[i].md);
            secret      = 7'(tv[i].sec);
            guess_valid = 1'(tv[i].gv);
            guess       = 7'(tv[i].g);
            @(posedge clk);
            #1;
            chk($sformatf("tv%0d.timer_restart", i), 32'(timer_restart), tv[i].rs);
            chk($sformatf("tv%0d.busy", i),          32'(busy),          tv[i].bz);
            chk($sformatf("tv%0d.too_high", i),      32'(too_high),      tv[i].hi);
            chk($sformatf("tv%0d.too_low", i),       32'(too_low),       tv[i].lo);
            chk($sformatf("tv%0d.bad_guess", i),     32'(bad_guess),     tv[i].bd);
            chk($sformatf("tv%0d.win", i),           32'(win),           tv[i].wn);
            chk($sformatf("tv%0d.lose", i),          32'(lose),          tv[i].ls);
            chk($sformatf("tv%0d.attempts", i),      32'(attempts),      tv[i].at);
        end
        start = 1'b0; guess_valid = 1'b0;

        // Timeout boundary at limit 32.
        do_reset();
        begin_round(2'd1, 7'd5, "to_arm");
        counter = 7'd31;
        cyc("to_31");
        chk("timeout_before_limit", 32'(lose), 0);
        counter = 7'd32;
        cyc("to_32");
        chk("timeout_at_limit", 32'(lose), 1);
        chk("timeout_restart", 32'(timer_restart), 0);

        // Out-of-range guess, then tries exhausted.
        do_reset();
        begin_round(2'd2, 7'd50, "tries_arm");
        guess = 7'd120; guess_valid = 1'b1;
        cyc("bad120");
        chk("bad_guess_set", 32'(bad_guess), 1);
        chk("bad_no_attempt", 32'(attempts), 0);
        for (int i = 0; i < 7; i++) begin
            guess = 7'(10 + i); guess_valid = 1'b1;
            cyc("tries_g");
            cyc("tries_j");
        end
        chk("tries_lose", 32'(lose), 1);
        chk("tries_attempts", 32'(attempts), 7);

        // Timeout beats a same-cycle guess; then reset mid-PLAY.
        do_reset();
        begin_round(2'd1, 7'd5, "race_arm");
        counter = 7'd32; guess = 7'd5; guess_valid = 1'b1;
        cyc("race");
        chk("race_lose", 32'(lose), 1);
        chk("race_win", 32'(win), 0);
        chk("race_attempts", 32'(attempts), 0);
        counter = 7'd0;
        begin_round(2'd1, 7'd4, "rst_arm");
        guess = 7'd9; guess_valid = 1'b1;
        cyc("rst_g");
        reset = 1'b1;
        #1;
        chk("midrst_restart", 32'(timer_restart), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_flags", {27'd0, too_high, too_low, bad_guess, win, lose}, 0);
        chk("midrst_attempts", 32'(attempts), 0);
        chk("midrst_score", 32'(score), 0);
        @(posedge clk);
        #1;
        reset = 1'b0; guess_valid = 1'b0;
        model_reset();

`ifdef GAME_SCORE_EN
        // Win at counter 20 on attempt 2 with limit 64: 44 + 4*5.
        do_reset();
        begin_round(2'd2, 7'd40, "score_arm");
        guess = 7'd10; guess_valid = 1'b1;
        cyc("score_g1");
        cyc("score_j1");
        counter = 7'd20; guess = 7'd40; guess_valid = 1'b1;
        cyc("score_g2");
        cyc("score_j2");
        chk("score_value", 32'(score), 64);
`endif

        // Random play against the model, with a behavioural timer on counter.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            start       = ($urandom % 16) == 0;
            Max_digit   = 2'($urandom);
            secret      = ($urandom % 4 == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 9));
            guess_valid = ($urandom % 3) == 0;
            guess       = ($urandom % 4 == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 12));
            cyc("rand");
            if (m_restart() != 0) counter = (counter == 7'd127) ? counter : counter + 7'd1;
            else                  counter = 7'd0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
